// File: rtl/code39_pkg.sv
// Shared types, constants and the Code39 pattern-to-ASCII table for the decoder.
package code39_pkg;

    localparam int unsigned NUM_ELEM = 9;
    localparam logic [8:0]  STAR_PAT = 9'h094;
    localparam logic [7:0]  TERM     = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StMeasure,
        StGap,
        StWrite,
        StDone,
        StError
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] ascii;
    } lookup_t;

    // Pattern bit 8 is the first bar; a set bit marks a wide element.
    function automatic lookup_t pat_to_ascii(input logic [8:0] pat);
        lookup_t r;
        r.valid = 1'b1;
        r.ascii = 8'h00;
        case (pat)
            9'h034: r.ascii = 8'h30;
            9'h121: r.ascii = 8'h31;
            9'h061: r.ascii = 8'h32;
            9'h160: r.ascii = 8'h33;
            9'h031: r.ascii = 8'h34;
            9'h130: r.ascii = 8'h35;
            9'h070: r.ascii = 8'h36;
            9'h025: r.ascii = 8'h37;
            9'h124: r.ascii = 8'h38;
            9'h064: r.ascii = 8'h39;
            9'h109: r.ascii = 8'h41;
            9'h049: r.ascii = 8'h42;
            9'h148: r.ascii = 8'h43;
            9'h019: r.ascii = 8'h44;
            9'h118: r.ascii = 8'h45;
            9'h058: r.ascii = 8'h46;
            9'h00D: r.ascii = 8'h47;
            9'h10C: r.ascii = 8'h48;
            9'h04C: r.ascii = 8'h49;
            9'h01C: r.ascii = 8'h4A;
            9'h103: r.ascii = 8'h4B;
            9'h043: r.ascii = 8'h4C;
            9'h142: r.ascii = 8'h4D;
            9'h013: r.ascii = 8'h4E;
            9'h112: r.ascii = 8'h4F;
            9'h052: r.ascii = 8'h50;
            9'h007: r.ascii = 8'h51;
            9'h106: r.ascii = 8'h52;
            9'h046: r.ascii = 8'h53;
            9'h016: r.ascii = 8'h54;
            9'h181: r.ascii = 8'h55;
            9'h0C1: r.ascii = 8'h56;
            9'h1C0: r.ascii = 8'h57;
            9'h091: r.ascii = 8'h58;
            9'h190: r.ascii = 8'h59;
            9'h0D0: r.ascii = 8'h5A;
            9'h085: r.ascii = 8'h2D;
            9'h184: r.ascii = 8'h2E;
            9'h0C4: r.ascii = 8'h20;
            9'h094: r.ascii = 8'h2A;
            9'h0A8: r.ascii = 8'h24;
            9'h0A2: r.ascii = 8'h2F;
            9'h08A: r.ascii = 8'h2B;
            9'h02A: r.ascii = 8'h25;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/code39_classify.sv
// Combinational wide/narrow classifier: an element is wide when it exceeds the mean width.
module code39_classify
    import code39_pkg::*;
#(
    parameter int unsigned CNT_W = 12
) (
    input  logic [NUM_ELEM-1:0][CNT_W-1:0] widths,
    output logic [NUM_ELEM-1:0]            pattern,
    output logic                           three_wide
);

    localparam int unsigned SumW = CNT_W + 4;

    logic [SumW-1:0] sum;

    // 9*w > sum compares against the mean without a divider.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            sum = sum + SumW'(widths[i]);
        end
        for (int i = 0; i < NUM_ELEM; i++) begin
            pattern[NUM_ELEM-1-i] = (SumW'(widths[i]) * SumW'(NUM_ELEM)) > sum;
        end
    end

    assign three_wide = ($countones(pattern) == 3);

endmodule

// File: rtl/code39_decoder.sv
// Code39 barcode decoder: measures bar/space runs, classifies characters and writes ASCII to RAM.
module code39_decoder
    import code39_pkg::*;
#(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_in,
    output logic              MEMW,
    output logic              MEMR,
    output logic              CS,
    output logic [ADDR_W-1:0] Address,
    inout  wire logic [7:0]   data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] char_count
);

    localparam logic [CNT_W-1:0]  CntMax  = '1;
    localparam logic [ADDR_W-1:0] AddrMax = '1;

    state_e                     state_q, state_d;
    logic                       sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                 idx_q, idx_d;
    logic [7:0][CNT_W-1:0]      widths_q, widths_d;
    logic                       started_q, started_d;
    logic                       term_q, term_d;
    logic [7:0]                 wr_byte_q, wr_byte_d;
    logic [ADDR_W-1:0]          count_q, count_d;

    logic                       rise, fall, toggle;
    logic [NUM_ELEM-1:0][CNT_W-1:0] class_widths;
    logic [NUM_ELEM-1:0]        pattern;
    logic                       three_wide;
    lookup_t                    lut;
    logic [ADDR_W-1:0]          wr_addr;

    assign rise   = sync2_q & ~prev_q;
    assign fall   = ~sync2_q & prev_q;
    assign toggle = rise | fall;

    // The ninth element is classified from the live counter on its closing edge.
    assign class_widths = {cnt_q, widths_q};
    assign lut          = pat_to_ascii(pattern);
    assign wr_addr      = ADDR_W'(BASE_ADDR) + count_q;

    code39_classify #(
        .CNT_W (CNT_W)
    ) u_classify (
        .widths     (class_widths),
        .pattern    (pattern),
        .three_wide (three_wide)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            widths_q  <= '0;
            started_q <= 1'b0;
            term_q    <= 1'b0;
            wr_byte_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= scan_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            widths_q  <= widths_d;
            started_q <= started_d;
            term_q    <= term_d;
            wr_byte_q <= wr_byte_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        widths_d  = widths_q;
        started_d = started_q;
        term_d    = term_q;
        wr_byte_d = wr_byte_q;
        count_d   = count_q;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeasure;
                    idx_d   = 4'd0;
                    cnt_d   = CNT_W'(1);
                end
            end
            StMeasure: begin
                if (cnt_q == CntMax) begin
                    state_d = StError;
                end else if (toggle) begin
                    cnt_d = CNT_W'(1);
                    if (idx_q == 4'(NUM_ELEM - 1)) begin
                        if (!three_wide || !lut.valid) begin
                            state_d = StError;
                        end else if (!started_q) begin
                            if (pattern == STAR_PAT) begin
                                started_d = 1'b1;
                                state_d   = StGap;
                            end else begin
                                state_d = StError;
                            end
                        end else if (pattern == STAR_PAT) begin
                            wr_byte_d = TERM;
                            term_d    = 1'b1;
                            state_d   = StWrite;
                        end else if (wr_addr == AddrMax) begin
                            // Last address is reserved for the terminator.
                            state_d = StError;
                        end else begin
                            wr_byte_d = lut.ascii;
                            term_d    = 1'b0;
                            state_d   = StWrite;
                        end
                    end else begin
                        widths_d[idx_q[2:0]] = cnt_q;
                        idx_d                = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntMax) begin
                    state_d = StError;
                end else if (rise) begin
                    state_d = StMeasure;
                    idx_d   = 4'd0;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: begin
                if (term_q) begin
                    state_d = StDone;
                end else begin
                    count_d = count_q + 1'b1;
                    if (rise) begin
                        state_d = StMeasure;
                        idx_d   = 4'd0;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = StGap;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign MEMW       = (state_q == StWrite);
    assign CS         = MEMW;
    assign MEMR       = 1'b0;
    assign Address    = MEMW ? wr_addr : '0;
    assign data       = MEMW ? wr_byte_q : 8'bz;
    assign done       = (state_q == StDone);
    assign err        = (state_q == StError);
    assign char_count = count_q;

endmodule

// File: tb/tb_code39_decoder.sv
// Bench for code39_decoder: two instances (low and high base address) driven by the same
// directed and random Code39 symbols, checked against a behavioural symbol-level model.
module tb_code39_decoder;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned HI_BASE = 1020;

    typedef struct {
        int addr;
        int dat;
        int cyc;
    } wr_t;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              scan_in = 1'b0;
    logic [1:0]        memw, memr, cs, done, err;
    logic [ADDR_W-1:0] addr0, addr1, cnt0, cnt1;
    wire  [7:0]        data0, data1;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   memr_seen = 1'b0;
    bit   cs_bad    = 1'b0;
    wr_t  wlog0[$];
    wr_t  wlog1[$];
    logic [7:0] ram0 [1024];
    logic [7:0] ram1 [1024];
    logic [8:0] sym[$];
    int   fall_cyc[$];

    string chars = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ-. *$/+%";
    logic [8:0] pat_tab [44] = '{
        9'h034, 9'h121, 9'h061, 9'h160, 9'h031, 9'h130, 9'h070, 9'h025, 9'h124, 9'h064,
        9'h109, 9'h049, 9'h148, 9'h019, 9'h118, 9'h058, 9'h00D, 9'h10C, 9'h04C, 9'h01C,
        9'h103, 9'h043, 9'h142, 9'h013, 9'h112, 9'h052, 9'h007, 9'h106, 9'h046, 9'h016,
        9'h181, 9'h0C1, 9'h1C0, 9'h091, 9'h190, 9'h0D0, 9'h085, 9'h184, 9'h0C4, 9'h094,
        9'h0A8, 9'h0A2, 9'h08A, 9'h02A
    };

    code39_decoder #(
        .CNT_W     (CNT_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0)
    ) u_dut_lo (
        .clk        (clk),
        .rst        (rst),
        .scan_in    (scan_in),
        .MEMW       (memw[0]),
        .MEMR       (memr[0]),
        .CS         (cs[0]),
        .Address    (addr0),
        .data       (data0),
        .done       (done[0]),
        .err        (err[0]),
        .char_count (cnt0)
    );

    code39_decoder #(
        .CNT_W     (CNT_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (HI_BASE)
    ) u_dut_hi (
        .clk        (clk),
        .rst        (rst),
        .scan_in    (scan_in),
        .MEMW       (memw[1]),
        .MEMR       (memr[1]),
        .CS         (cs[1]),
        .Address    (addr1),
        .data       (data1),
        .done       (done[1]),
        .err        (err[1]),
        .char_count (cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM models and bus monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (memw[0]) begin
            wlog0.push_back('{int'(addr0), int'(data0), cyc});
            ram0[addr0] = data0;
        end
        if (memw[1]) begin
            wlog1.push_back('{int'(addr1), int'(data1), cyc});
            ram1[addr1] = data1;
        end
        if (memr != 2'b00) memr_seen = 1'b1;
        if (cs != memw) cs_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] enc(input byte c);
        for (int i = 0; i < 44; i++) begin
            if (chars[i] == c) return pat_tab[i];
        end
        return 9'h000;
    endfunction

    // ASCII code of a table pattern, or -1 when the pattern is not a Code39 character.
    function automatic int lookup(input logic [8:0] p);
        for (int i = 0; i < 44; i++) begin
            if (pat_tab[i] == p) return int'(chars[i]);
        end
        return -1;
    endfunction

    function automatic logic [8:0] bad_pat();
        logic [8:0] p;
        p = 9'(($urandom_range(1, 511)));
        while (lookup(p) >= 0) p = 9'(($urandom_range(1, 511)));
        return p;
    endfunction

    task automatic load(input string s);
        sym.delete();
        for (int i = 0; i < s.len(); i++) sym.push_back(enc(s[i]));
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        scan_in = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
        wlog0.delete();
        wlog1.delete();
        memr_seen = 1'b0;
        cs_bad    = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " memw"}, 32'(memw), 32'd0);
        check({tag, " cs"}, 32'(cs), 32'd0);
        check({tag, " memr"}, 32'(memr), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " addr_lo"}, 32'(addr0), 32'd0);
        check({tag, " addr_hi"}, 32'(addr1), 32'd0);
        check({tag, " count_lo"}, 32'(cnt0), 32'd0);
        check({tag, " count_hi"}, 32'(cnt1), 32'd0);
    endtask

    // Drives sym as bar/space runs; optionally pulls rst mid-element and returns early.
    task automatic send(input int n, input int w, input int abort_ch, input int abort_el);
        fall_cyc.delete();
        foreach (sym[k]) begin
            for (int e = 0; e < 9; e++) begin
                int len;
                len     = sym[k][8-e] ? w : n;
                scan_in = (e % 2 == 0);
                if (k == abort_ch && e == abort_el) begin
                    step(len / 2);
                    rst = 1'b0;
                    step(1);
                    return;
                end
                step(len);
            end
            scan_in = 1'b0;
            fall_cyc.push_back(cyc);
            step($urandom_range(n, 2 * w));
        end
    endtask

    // Symbol-level reference: walks the characters and compares outcome and writes.
    task automatic verify(input int inst, input string tag);
        wr_t got[$];
        int  ea[$], ed[$], ec[$];
        int  base, a, cnt, e_done, e_err, g_done, g_err, g_cnt;
        bit  started;
        if (inst == 0) begin
            got = wlog0; base = 0;
            g_done = int'(done[0]); g_err = int'(err[0]); g_cnt = int'(cnt0);
        end else begin
            got = wlog1; base = int'(HI_BASE);
            g_done = int'(done[1]); g_err = int'(err[1]); g_cnt = int'(cnt1);
        end
        cnt = 0; e_done = 0; e_err = 0; started = 1'b0;
        foreach (sym[k]) begin
            if (e_done != 0 || e_err != 0) break;
            a = lookup(sym[k]);
            if (a < 0) e_err = 1;
            else if (!started) begin
                if (a == 8'h2A) started = 1'b1;
                else e_err = 1;
            end else if (a == 8'h2A) begin
                ea.push_back(base + cnt); ed.push_back(0); ec.push_back(fall_cyc[k] + 3);
                e_done = 1;
            end else if (base + cnt == 1023) e_err = 1;
            else begin
                ea.push_back(base + cnt); ed.push_back(a); ec.push_back(fall_cyc[k] + 3);
                cnt++;
            end
        end
        check({tag, " done"}, g_done, e_done);
        check({tag, " err"}, g_err, e_err);
        check({tag, " char_count"}, g_cnt, cnt);
        check({tag, " writes"}, got.size(), ea.size());
        for (int i = 0; i < got.size() && i < ea.size(); i++) begin
            check($sformatf("%s wr%0d addr", tag, i), got[i].addr, ea[i]);
            check($sformatf("%s wr%0d data", tag, i), got[i].dat, ed[i]);
            check($sformatf("%s wr%0d latency", tag, i), got[i].cyc, ec[i]);
        end
        check({tag, " memr"}, 32'(memr_seen), 32'd0);
        check({tag, " cs"}, 32'(cs_bad), 32'd0);
    endtask

    initial begin
        int n, w, mode, len, j, f;
        bit hit;

        step(2);
        check_reset("reset");
        rst = 1'b1;
        step(2);

        // "*A1*" with narrow 10 / wide 25.
        do_reset();
        load("*A1*");
        send(10, 25, -1, -1);
        step(20);
        verify(0, "a1 lo");
        verify(1, "a1 hi");
        check("a1 ram0", 32'(ram0[0]), 32'h41);
        check("a1 ram1", 32'(ram0[1]), 32'h31);
        check("a1 ram2", 32'(ram0[2]), 32'h00);

        // Bad start character.
        do_reset();
        load("AB*");
        send(10, 25, -1, -1);
        step(20);
        verify(0, "nostart lo");
        verify(1, "nostart hi");

        // Four wide elements after a valid start.
        do_reset();
        load("*");
        sym.push_back(9'h1E0);
        sym.push_back(enc("B"));
        sym.push_back(enc("*"));
        send(10, 25, -1, -1);
        step(20);
        verify(0, "fourwide lo");
        verify(1, "fourwide hi");

        // Space after the start character held until the counter saturates.
        do_reset();
        load("*");
        send(10, 25, -1, -1);
        f = fall_cyc[0];
        step(f + 4090 - cyc);
        check("timeout early", 32'(err), 32'd0);
        step(15);
        check("timeout err", 32'(err), 32'd3);
        check("timeout writes", wlog0.size() + wlog1.size(), 0);

        // Overflow at the top of RAM for the high instance.
        do_reset();
        load("*ABCD*");
        send(8, 20, -1, -1);
        step(20);
        verify(0, "ovf lo");
        verify(1, "ovf hi");
        hit = 1'b0;
        foreach (wlog1[i]) if (wlog1[i].addr == 1023) hit = 1'b1;
        check("ovf no write 1023", 32'(hit), 32'd0);

        // Reset in element 5 of the second character, then a fresh symbol.
        do_reset();
        load("*AB*");
        send(10, 25, 1, 4);
        check_reset("abort");
        rst     = 1'b1;
        scan_in = 1'b0;
        step(30);
        check("abort no write", wlog0.size() + wlog1.size(), 0);
        load("*Z*");
        send(10, 25, -1, -1);
        step(20);
        verify(0, "fresh lo");
        verify(1, "fresh hi");
        check("fresh ram0", 32'(ram0[0]), 32'h5A);
        check("fresh ram1", 32'(ram0[1]), 32'h00);

        // Random symbols: valid payloads, bad start, invalid patterns.
        for (int t = 0; t < 14; t++) begin
            do_reset();
            n    = $urandom_range(3, 9);
            w    = 2 * n + $urandom_range(0, n);
            mode = $urandom_range(0, 7);
            sym.delete();
            if (mode == 0) begin
                j = $urandom_range(0, 42);
                if (j >= 39) j++;
                sym.push_back(pat_tab[j]);
            end else begin
                sym.push_back(enc("*"));
            end
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
                j = $urandom_range(0, 42);
                if (j >= 39) j++;
                sym.push_back(pat_tab[j]);
            end
            if (mode == 1) sym.insert($urandom_range(1, sym.size()), bad_pat());
            sym.push_back(enc("*"));
            send(n, w, -1, -1);
            step(20);
            verify(0, $sformatf("rnd%0d lo", t));
            verify(1, $sformatf("rnd%0d hi", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
